// File: rtl/reg_file.sv
// reg_file: 32 x DATA_W register file with two combinational read ports,
// one write port, optional write-to-read forwarding and a debug write counter.
// Register 0 is hardwired to zero; writes to it are discarded and not counted.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr1,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [15:0]       wcount
);

  logic [DATA_W-1:0] regs [0:31];
  logic              commit;

  // A write only counts when it targets a real register and reset is released.
  assign commit = we && (waddr != 5'd0) && !rst;

  // Storage update: async clear of every entry, otherwise one write per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[waddr] <= wdata;
    end
  end

  // Committed-write counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcount <= 16'd0;
    end else if (commit) begin
      wcount <= wcount + 16'd1;
    end
  end

  // Read port 1: zero during reset or for r0, forwarded data on a same-cycle hit.
  always_comb begin
    rdata1 = '0;
    if (!rst && (raddr1 != 5'd0)) begin
      if ((BYPASS != 0) && commit && (raddr1 == waddr)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs[raddr1];
      end
    end
  end

  // Read port 2: same rules as port 1, fully independent.
  always_comb begin
    rdata2 = '0;
    if (!rst && (raddr2 != 5'd0)) begin
      if ((BYPASS != 0) && commit && (raddr2 == waddr)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs[raddr2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: one forwarding and one non-forwarding
// instance share all inputs and are compared against an array-based model.
module tb_reg_file;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [31:0] rdata1_b, rdata2_b, rdata1_nb, rdata2_nb;
   logic [15:0] wcount_b, wcount_nb;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: plain array of register values and an integer write count.
   logic [31:0] mem [0:31];
   int          wcnt;

   reg_file #(.DATA_W(32), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1_b), .rdata2(rdata2_b), .wcount(wcount_b)
   );

   reg_file #(.DATA_W(32), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1_nb), .rdata2(rdata2_nb), .wcount(wcount_nb)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Clear the model, as reset does to the hardware.
   task automatic modelReset();
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      wcnt = 0;
   endtask

   // What a read port must show right now, from the rules alone.
   function automatic logic [31:0] expRead(input bit byp, input logic [4:0] a);
      if (rst) return 32'd0;
      if (a == 5'd0) return 32'd0;
      if (byp && we && waddr != 5'd0 && a == waddr) return wdata;
      return mem[a];
   endfunction

   // Advance one clock edge and apply its effect to the model, then settle.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         modelReset();
      end else if (we && waddr != 5'd0) begin
         mem[waddr] = wdata;
         wcnt = (wcnt + 1) % 65536;
      end
      #1;
   endtask

   // Drive one set of inputs and let combinational reads settle.
   task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] r1, input logic [4:0] r2);
      we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2;
      #2;
   endtask

   // Compare all outputs of both instances against the model.
   task automatic checkReads(input string tag);
      checkOutput({tag, "_r1_byp"},   rdata1_b,  expRead(1'b1, raddr1));
      checkOutput({tag, "_r2_byp"},   rdata2_b,  expRead(1'b1, raddr2));
      checkOutput({tag, "_r1_nobyp"}, rdata1_nb, expRead(1'b0, raddr1));
      checkOutput({tag, "_r2_nobyp"}, rdata2_nb, expRead(1'b0, raddr2));
      checkOutput({tag, "_wcnt_byp"},   {16'd0, wcount_b},  wcnt[31:0]);
      checkOutput({tag, "_wcnt_nobyp"}, {16'd0, wcount_nb}, wcnt[31:0]);
   endtask

   // Sweep every address through both ports and compare against the model.
   task automatic dumpAll(input string tag);
      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i); raddr2 = 5'(31 - i);
         #1;
         checkReads(tag);
      end
   endtask

   // Main sequence: directed scenarios, random traffic, async reset, counter wrap.
   initial begin
      logic [4:0] wa, r1, r2;
      logic       w;
      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
      modelReset();
      #3;
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
      checkReads("reset");
      step();
      step();
      rst = 1'b0;

      // Basic write then read back.
      applyStimulus(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5);
      checkReads("w5_pre");
      step();
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
      checkReads("w5_post");
      checkOutput("w5_data", rdata1_b, 32'h12345678);
      checkOutput("w5_wcount", {16'd0, wcount_b}, 32'd1);

      // Writes to r0 are discarded, even through the forwarding path.
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      checkOutput("r0_pre", rdata1_b, 32'd0);
      step();
      checkOutput("r0_post", rdata1_b, 32'd0);
      checkOutput("r0_wcount", {16'd0, wcount_b}, 32'd1);

      // Forwarding versus no forwarding on register 31.
      applyStimulus(1'b1, 5'd31, 32'hA, 5'd0, 5'd31);
      step();
      applyStimulus(1'b1, 5'd31, 32'hB, 5'd0, 5'd31);
      checkOutput("fwd_same_cycle", rdata2_b, 32'hB);
      checkOutput("nofwd_before_edge", rdata2_nb, 32'hA);
      step();
      checkOutput("nofwd_after_edge", rdata2_nb, 32'hB);
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
      checkReads("r31_hold");

      // Undriven read addresses must not disturb stored state.
      applyStimulus(1'b1, 5'd9, 32'hDEAD0009, 5'bx, 5'bx);
      step();
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd5);
      checkReads("xaddr");

      // Random traffic with reads biased towards the write address.
      for (int n = 0; n < 400; n++) begin
         w  = ($urandom_range(0, 3) != 0);
         wa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         r1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
         r2 = ($urandom_range(0, 3) == 0) ? r1 : (($urandom_range(0, 2) == 0) ? wa : 5'($urandom));
         applyStimulus(w, wa, $urandom, r1, r2);
         checkReads("rand");
         step();
      end

      // Fill 1..31 with their index, then assert reset between edges.
      for (int i = 1; i < 32; i++) begin
         applyStimulus(1'b1, 5'(i), 32'(i), 5'(i), 5'd0);
         step();
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
      checkReads("filled");
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("async_rst_wcount", {16'd0, wcount_b}, 32'd0);
      dumpAll("async_rst");
      // A write presented during reset must be dropped.
      applyStimulus(1'b1, 5'd3, 32'hFF, 5'd3, 5'd3);
      checkReads("rst_bypass");
      step();
      rst = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd7);
      checkReads("rst_release");
      step();
      checkReads("rst_release_edge");
      applyStimulus(1'b1, 5'd7, 32'h77, 5'd7, 5'd3);
      step();
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd7, 5'd3);
      checkReads("first_write");
      checkOutput("first_write_wcount", {16'd0, wcount_b}, 32'd1);

      // Counter wrap: exactly 65536 committed writes from a clean reset.
      rst = 1'b1;
      modelReset();
      step();
      rst = 1'b0;
      for (int n = 0; n < 65536; n++) begin
         we = 1'b1; waddr = 5'($urandom_range(1, 31)); wdata = $urandom;
         step();
         if (n == 65534) checkOutput("wcount_ffff", {16'd0, wcount_b}, 32'h0000FFFF);
      end
      we = 1'b0;
      #1;
      checkOutput("wcount_wrap", {16'd0, wcount_b}, 32'd0);
      dumpAll("after_wrap");

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
